// File: rtl/serial_bit_error_counter.sv
// Frame-based bit-error counter: compares reference/received serial bits and reports
// the mismatch count per FRAME_LEN-beat frame. Define BIT_ERR_PIPE_EN for a pipelined compare stage.

module xor_gate_using_mux (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  // b selects between a and its complement, which is exactly a ^ b.
  assign o_y = i_b ? ~i_a : i_a;
endmodule

module serial_bit_error_counter #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_any,
  output logic             out_vld,
  input  logic             out_rdy
);

  localparam int             IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

`ifdef BIT_ERR_PIPE_EN
  localparam state_t ST_AFTER_LAST = ST_DRAIN;
`else
  localparam state_t ST_AFTER_LAST = ST_REPORT;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               r_err_any;
  logic               r_out_vld;

  logic               w_diff;
  logic               w_accept;
  logic               w_last_beat;
  logic               w_acc_vld;
  logic               w_acc_diff;
  logic               w_acc_last;
  logic [CNT_W-1:0]   w_acc_sum;

  xor_gate_using_mux u_xor (
    .i_a (a),
    .i_b (b),
    .o_y (w_diff)
  );

  assign in_rdy      = (r_state == ST_COUNT);
  assign w_accept    = in_vld & in_rdy;
  assign w_last_beat = (r_idx == IDX_LAST);

  // Beat index advances at the accept point, independent of the optional pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
    end else if (w_accept) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_idx <= w_last_beat ? '0 : r_idx + 1'b1;
    end
  end

`ifdef BIT_ERR_PIPE_EN
  logic r_p_vld;
  logic r_p_diff;
  logic r_p_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p_vld  <= 1'b0;
      r_p_diff <= 1'b0;
      r_p_last <= 1'b0;
    end else begin
      r_p_vld  <= w_accept;
      r_p_diff <= w_diff;
      r_p_last <= w_accept & w_last_beat;
    end
  end

  assign w_acc_vld  = r_p_vld;
  assign w_acc_diff = r_p_diff;
  assign w_acc_last = r_p_last;
`else
  assign w_acc_vld  = w_accept;
  assign w_acc_diff = w_diff;
  assign w_acc_last = w_accept & w_last_beat;
`endif

  // FRAME_LEN fits in CNT_W bits, so the running sum cannot wrap.
  assign w_acc_sum = r_acc + CNT_W'(w_acc_diff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (w_acc_vld) begin
      r_acc <= w_acc_last ? '0 : w_acc_sum;
    end
  end

  // Result registers: loaded on the frame's final beat, held across backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
      r_err_any <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (w_acc_vld && w_acc_last) begin
      r_err_cnt <= w_acc_sum;
      r_err_any <= |w_acc_sum;
      r_out_vld <= 1'b1;
    end else if (r_out_vld && out_rdy) begin
      r_out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_COUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves the output unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      ST_COUNT:  if (w_accept && w_last_beat) w_state_nxt = ST_AFTER_LAST;
      ST_DRAIN:  w_state_nxt = ST_REPORT;
      ST_REPORT: if (r_out_vld && out_rdy)    w_state_nxt = ST_COUNT;
      default:   w_state_nxt = ST_COUNT;
    endcase
  end

  assign err_cnt = r_err_cnt;
  assign err_any = r_err_any;
  assign out_vld = r_out_vld;

endmodule

// File: tb/tb_serial_bit_error_counter.sv
// Scoreboard bench for serial_bit_error_counter (FRAME_LEN=8, CNT_W=4); honours BIT_ERR_PIPE_EN.

module tb_serial_bit_error_counter;

  localparam int FL = 8;
  localparam int CW = 4;
`ifdef BIT_ERR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a = 1'b0;
  logic          b = 1'b0;
  logic          in_vld = 1'b0;
  logic          out_rdy = 1'b0;
  logic          in_rdy;
  logic [CW-1:0] err_cnt;
  logic          err_any;
  logic          out_vld;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [3:0] cnt;
    logic       any;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  exp_t mon_e;

  serial_bit_error_counter #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .err_cnt (err_cnt),
    .err_any (err_any),
    .out_vld (out_vld),
    .out_rdy (out_rdy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a result leaves the DUT whenever out_vld && out_rdy is seen before an edge.
  always @(negedge clk) begin
    if (rst && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        check("unexpected result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("err_cnt", 32'(err_cnt), 32'(mon_e.cnt));
        check("err_any", 32'(err_any), 32'(mon_e.any));
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic drive_beat(input logic ba, input logic bb);
    bit ok = 0;
    a = ba;
    b = bb;
    in_vld = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (in_rdy && rst) ok = 1;
      @(posedge clk);
      #1;
    end
    if (!ok) check("beat accept timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] gaps);
    for (int i = 0; i < FL; i++) begin
      if (gaps[i]) begin
        in_vld = 1'b0;
        @(posedge clk);
        #1;
      end
      drive_beat(va[7-i], vb[7-i]);
    end
  endtask

  task automatic wait_out_vld();
    bit ok = 0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clk);
      if (out_vld) ok = 1;
    end
    if (!ok) check("out_vld timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a beat presented; it must not be counted.
    #1 rst = 1'b0;
    a = 1'b1; b = 1'b0; in_vld = 1'b1;
    #2;
    check("rst out_vld", 32'(out_vld), 0);
    check("rst err_cnt", 32'(err_cnt), 0);
    check("rst err_any", 32'(err_any), 0);
    check("rst in_rdy",  32'(in_rdy), 1);
    #19 in_vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    // Equal streams, latency and single-cycle pulse.
    out_rdy = 1'b1;
    sb.push_back('{cnt: 4'd0, any: 1'b0});
    send_frame(8'b10110010, 8'b10110010, 8'h00);
    in_vld = 1'b0;
    @(negedge clk);
    if (LAT == 2) begin
      check("latency early", 32'(out_vld), 0);
      @(negedge clk);
    end
    check("latency", 32'(out_vld), 1);
    @(negedge clk);
    check("out_vld pulse", 32'(out_vld), 0);
    @(posedge clk); #1;

    // All mismatched: full-scale count.
    sb.push_back('{cnt: 4'd8, any: 1'b1});
    send_frame(8'hFF, 8'h00, 8'h00);
    in_vld = 1'b0;
    wait_out_vld();
    @(posedge clk); #1;
    @(negedge clk);
    check("err_cnt kept", 32'(err_cnt), 8);
    check("out_vld cleared", 32'(out_vld), 0);
    @(posedge clk); #1;

    // Gaps at beats 2 and 5, then 4 cycles of backpressure.
    out_rdy = 1'b0;
    sb.push_back('{cnt: 4'd3, any: 1'b1});
    send_frame(8'h00, 8'b10010100, 8'b00100100);
    in_vld = 1'b0;
    wait_out_vld();
    for (int k = 0; k < 4; k++) begin
      check("bp out_vld", 32'(out_vld), 1);
      check("bp err_cnt", 32'(err_cnt), 3);
      check("bp in_rdy",  32'(in_rdy), 0);
      if (k < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("in_rdy after handshake", 32'(in_rdy), 1);
    @(posedge clk); #1;

    // Mid-frame reset discards a partial frame with 2 mismatches.
    for (int i = 0; i < 5; i++) drive_beat(i < 2, 1'b0);
    #1 rst = 1'b0;
    a = 1'b1; b = 1'b0; in_vld = 1'b1;
    #1;
    check("midrst err_cnt", 32'(err_cnt), 0);
    check("midrst err_any", 32'(err_any), 0);
    check("midrst out_vld", 32'(out_vld), 0);
    check("midrst in_rdy",  32'(in_rdy), 1);
    repeat (2) @(posedge clk);
    #2 in_vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{cnt: 4'd1, any: 1'b1});
    send_frame(8'b00010000, 8'h00, 8'h00);
    in_vld = 1'b0;
    wait_out_vld();
    @(posedge clk); #1;

    // Reset while a result of 6 is waiting.
    out_rdy = 1'b0;
    send_frame(8'b11111100, 8'h00, 8'h00);
    in_vld = 1'b0;
    wait_out_vld();
    check("report err_cnt", 32'(err_cnt), 6);
    check("report err_any", 32'(err_any), 1);
    #2 rst = 1'b0;
    #1;
    check("rptrst out_vld", 32'(out_vld), 0);
    check("rptrst err_cnt", 32'(err_cnt), 0);
    check("rptrst err_any", 32'(err_any), 0);
    check("rptrst in_rdy",  32'(in_rdy), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    check("post-rst out_vld", 32'(out_vld), 0);
    @(posedge clk); #1;

    // Back-to-back frames with in_vld and out_rdy held high.
    sb.push_back('{cnt: 4'd4, any: 1'b1});
    sb.push_back('{cnt: 4'd7, any: 1'b1});
    send_frame(8'b11110000, 8'h00, 8'h00);
    send_frame(8'b11111110, 8'h00, 8'h00);
    in_vld = 1'b0;
    wait_out_vld();
    @(posedge clk); #1;
    @(negedge clk);
    if (pop_cyc.size() >= 2)
      check("frame period", 32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2]), 32'(FL + LAT));
    else
      check("frame period samples", 32'(pop_cyc.size()), 2);
    check("scoreboard drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
